// File: rtl/decode_execute_register.sv
// Decode -> execute pipeline register.
//
// Captures the decode-stage control word and operands every cycle. A stall holds the slot and
// a flush replaces the captured instruction with a bubble. The block also owns the NZCV
// condition-flags register and evaluates the branch/predication condition of the instruction
// that currently occupies the execute slot. Because that gating happens here, RegWriteE,
// MemWriteE and BranchTakenE are final and need no further qualification downstream.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   StallE, FlushE      hold the E slot / insert a bubble (flush wins over stall)
//   *D                  decode-stage control, operands, immediate and destination index
//   ALUFlagsE           NZCV produced by the ALU for the instruction in E this cycle
//   *E (copies)         registered control/data for the execute stage
//   RegWriteE/MemWriteE registered write enables qualified by ValidE and the condition
//   BranchTakenE        ValidE & BranchE & condition
//   ValidE              E slot holds a real instruction
//   FlagsE              current NZCV register, N in the MSB

module decode_execute_register #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                StallE,
  input  logic                FlushE,
  input  logic                RegWriteD,
  input  logic                MemtoRegD,
  input  logic                MemWriteD,
  input  logic                ALUSrcD,
  input  logic                BranchD,
  input  logic                FlagWriteD,
  input  logic [2:0]          ALUControlD,
  input  logic [2:0]          CondD,
  input  logic [WIDTH-1:0]    RD1D,
  input  logic [WIDTH-1:0]    RD2D,
  input  logic [WIDTH-1:0]    ExtImmD,
  input  logic [REG_BITS-1:0] RdD,
  input  logic [3:0]          ALUFlagsE,
  output logic                MemtoRegE,
  output logic                ALUSrcE,
  output logic [2:0]          ALUControlE,
  output logic [WIDTH-1:0]    RD1E,
  output logic [WIDTH-1:0]    RD2E,
  output logic [WIDTH-1:0]    ExtImmE,
  output logic [REG_BITS-1:0] RdE,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                BranchTakenE,
  output logic                ValidE,
  output logic [3:0]          FlagsE
);

  // Condition codes carried with every instruction.
  localparam logic [2:0] CondAl = 3'b000;
  localparam logic [2:0] CondEq = 3'b001;
  localparam logic [2:0] CondNe = 3'b010;
  localparam logic [2:0] CondGt = 3'b011;
  localparam logic [2:0] CondLt = 3'b100;

  // ---------------------------------------------------------------------------------------------
  // E-slot state
  // ---------------------------------------------------------------------------------------------
  logic                valid_q,        valid_d;
  logic                reg_write_q,    reg_write_d;
  logic                mem_to_reg_q,   mem_to_reg_d;
  logic                mem_write_q,    mem_write_d;
  logic                alu_src_q,      alu_src_d;
  logic                branch_q,       branch_d;
  logic                flag_write_q,   flag_write_d;
  logic [2:0]          alu_control_q,  alu_control_d;
  logic [2:0]          cond_q,         cond_d;
  logic [WIDTH-1:0]    rd1_q,          rd1_d;
  logic [WIDTH-1:0]    rd2_q,          rd2_d;
  logic [WIDTH-1:0]    ext_imm_q,      ext_imm_d;
  logic [REG_BITS-1:0] rd_q,           rd_d;

  // NZCV register
  logic [3:0]          flags_q,        flags_d;
  logic                flag_load;

  logic                cond_ex;
  logic                flag_n, flag_z, flag_v;

  // ---------------------------------------------------------------------------------------------
  // Slot next-state: flush > stall > capture
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    valid_d       = valid_q;
    reg_write_d   = reg_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    mem_write_d   = mem_write_q;
    alu_src_d     = alu_src_q;
    branch_d      = branch_q;
    flag_write_d  = flag_write_q;
    alu_control_d = alu_control_q;
    cond_d        = cond_q;
    rd1_d         = rd1_q;
    rd2_d         = rd2_q;
    ext_imm_d     = ext_imm_q;
    rd_d          = rd_q;

    if (FlushE) begin
      // Bubble clears data as well, so a flushed slot reads all-zero on every output.
      valid_d       = 1'b0;
      reg_write_d   = 1'b0;
      mem_to_reg_d  = 1'b0;
      mem_write_d   = 1'b0;
      alu_src_d     = 1'b0;
      branch_d      = 1'b0;
      flag_write_d  = 1'b0;
      alu_control_d = 3'b000;
      cond_d        = 3'b000;
      rd1_d         = '0;
      rd2_d         = '0;
      ext_imm_d     = '0;
      rd_d          = '0;
    end else if (!StallE) begin
      valid_d       = 1'b1;
      reg_write_d   = RegWriteD;
      mem_to_reg_d  = MemtoRegD;
      mem_write_d   = MemWriteD;
      alu_src_d     = ALUSrcD;
      branch_d      = BranchD;
      flag_write_d  = FlagWriteD;
      alu_control_d = ALUControlD;
      cond_d        = CondD;
      rd1_d         = RD1D;
      rd2_d         = RD2D;
      ext_imm_d     = ExtImmD;
      rd_d          = RdD;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Flags next-state
  // ---------------------------------------------------------------------------------------------
  // Uses the pre-edge slot contents. A flush only discards the incoming instruction, so the
  // instruction already in E still commits its flags; a stall keeps it in E, so it must not.
  assign flag_load = valid_q & flag_write_q & ~StallE;

  always_comb begin
    flags_d = flags_q;
    if (flag_load) begin
      flags_d = ALUFlagsE;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      alu_src_q     <= 1'b0;
      branch_q      <= 1'b0;
      flag_write_q  <= 1'b0;
      alu_control_q <= 3'b000;
      cond_q        <= 3'b000;
      rd1_q         <= '0;
      rd2_q         <= '0;
      ext_imm_q     <= '0;
      rd_q          <= '0;
      flags_q       <= 4'b0000;
    end else begin
      valid_q       <= valid_d;
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      mem_write_q   <= mem_write_d;
      alu_src_q     <= alu_src_d;
      branch_q      <= branch_d;
      flag_write_q  <= flag_write_d;
      alu_control_q <= alu_control_d;
      cond_q        <= cond_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      ext_imm_q     <= ext_imm_d;
      rd_q          <= rd_d;
      flags_q       <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------------------------------------
  // Only the committed flags register is consulted: flags from the previous instruction are
  // already loaded at the edge that brings this one into E, so sub -> beq needs no stall.
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[0];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_q)
      CondAl:  cond_ex = 1'b1;
      CondEq:  cond_ex = flag_z;
      CondNe:  cond_ex = ~flag_z;
      CondGt:  cond_ex = ~flag_z & (flag_n == flag_v);
      CondLt:  cond_ex = flag_n ^ flag_v;
      default: cond_ex = 1'b0; // reserved codes never execute
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs (from registers only)
  // ---------------------------------------------------------------------------------------------
  assign MemtoRegE    = mem_to_reg_q;
  assign ALUSrcE      = alu_src_q;
  assign ALUControlE  = alu_control_q;
  assign RD1E         = rd1_q;
  assign RD2E         = rd2_q;
  assign ExtImmE      = ext_imm_q;
  assign RdE          = rd_q;
  assign RegWriteE    = reg_write_q & valid_q & cond_ex;
  assign MemWriteE    = mem_write_q & valid_q & cond_ex;
  assign BranchTakenE = branch_q & valid_q & cond_ex;
  assign ValidE       = valid_q;
  assign FlagsE       = flags_q;

endmodule

// File: tb/tb_decode_execute_register.sv
// Bench for decode_execute_register: directed scenarios followed by randomized traffic, all
// compared against an instruction-level model of the E slot and the NZCV register.

module tb_decode_execute_register;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_BITS = 4;

  logic                clk;
  logic                rst;
  logic                StallE, FlushE;
  logic                RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, BranchD, FlagWriteD;
  logic [2:0]          ALUControlD, CondD;
  logic [WIDTH-1:0]    RD1D, RD2D, ExtImmD;
  logic [REG_BITS-1:0] RdD;
  logic [3:0]          ALUFlagsE;
  logic                MemtoRegE, ALUSrcE;
  logic [2:0]          ALUControlE;
  logic [WIDTH-1:0]    RD1E, RD2E, ExtImmE;
  logic [REG_BITS-1:0] RdE;
  logic                RegWriteE, MemWriteE, BranchTakenE, ValidE;
  logic [3:0]          FlagsE;

  decode_execute_register #(
    .WIDTH    (WIDTH),
    .REG_BITS (REG_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .MemWriteD    (MemWriteD),
    .ALUSrcD      (ALUSrcD),
    .BranchD      (BranchD),
    .FlagWriteD   (FlagWriteD),
    .ALUControlD  (ALUControlD),
    .CondD        (CondD),
    .RD1D         (RD1D),
    .RD2D         (RD2D),
    .ExtImmD      (ExtImmD),
    .RdD          (RdD),
    .ALUFlagsE    (ALUFlagsE),
    .MemtoRegE    (MemtoRegE),
    .ALUSrcE      (ALUSrcE),
    .ALUControlE  (ALUControlE),
    .RD1E         (RD1E),
    .RD2E         (RD2E),
    .ExtImmE      (ExtImmE),
    .RdE          (RdE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .BranchTakenE (BranchTakenE),
    .ValidE       (ValidE),
    .FlagsE       (FlagsE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One decoded instruction as the model sees it.
  typedef struct packed {
    logic                rw, mtr, mw, alusrc, br, fw;
    logic [2:0]          aluc, cond;
    logic [WIDTH-1:0]    rd1, rd2, imm;
    logic [REG_BITS-1:0] rd;
  } instr_t;

  instr_t     m_e;      // instruction held in E
  logic       m_valid;  // E holds a real instruction
  logic [3:0] m_flags;  // committed NZCV

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic cond_holds(input logic [2:0] cond, input logic [3:0] nzcv);
    logic n, z, v;
    n = nzcv[3];
    z = nzcv[2];
    v = nzcv[0];
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return !z && (n == v);
      3'd4:    return n != v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic instr_t cur_d();
    instr_t i;
    i.rw = RegWriteD;  i.mtr = MemtoRegD;  i.mw = MemWriteD;
    i.alusrc = ALUSrcD; i.br = BranchD;   i.fw = FlagWriteD;
    i.aluc = ALUControlD; i.cond = CondD;
    i.rd1 = RD1D; i.rd2 = RD2D; i.imm = ExtImmD; i.rd = RdD;
    return i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string where);
    logic ex;
    ex = cond_holds(m_e.cond, m_flags);
    chk({where, ".ValidE"},       32'(ValidE),       32'(m_valid));
    chk({where, ".FlagsE"},       32'(FlagsE),       32'(m_flags));
    chk({where, ".RegWriteE"},    32'(RegWriteE),    32'(m_valid & m_e.rw & ex));
    chk({where, ".MemWriteE"},    32'(MemWriteE),    32'(m_valid & m_e.mw & ex));
    chk({where, ".BranchTakenE"}, 32'(BranchTakenE), 32'(m_valid & m_e.br & ex));
    chk({where, ".MemtoRegE"},    32'(MemtoRegE),    32'(m_e.mtr));
    chk({where, ".ALUSrcE"},      32'(ALUSrcE),      32'(m_e.alusrc));
    chk({where, ".ALUControlE"},  32'(ALUControlE),  32'(m_e.aluc));
    chk({where, ".RD1E"},         RD1E,              m_e.rd1);
    chk({where, ".RD2E"},         RD2E,              m_e.rd2);
    chk({where, ".ExtImmE"},      ExtImmE,           m_e.imm);
    chk({where, ".RdE"},          32'(RdE),          32'(m_e.rd));
  endtask

  task automatic model_reset();
    m_e     = '0;
    m_valid = 1'b0;
    m_flags = 4'b0000;
  endtask

  // Advance one clock edge with the inputs currently driven, then compare.
  task automatic step(input string where);
    instr_t     nxt_e;
    logic       nxt_v;
    logic [3:0] nxt_f;
    nxt_f = (m_valid && m_e.fw && !StallE) ? ALUFlagsE : m_flags;
    nxt_e = m_e;
    nxt_v = m_valid;
    if (FlushE) begin
      nxt_e = '0;
      nxt_v = 1'b0;
    end else if (!StallE) begin
      nxt_e = cur_d();
      nxt_v = 1'b1;
    end
    @(posedge clk);
    m_e = nxt_e;
    m_valid = nxt_v;
    m_flags = nxt_f;
    #1;
    check_all(where);
  endtask

  task automatic set_d(input logic rw, input logic mtr, input logic mw, input logic br,
                       input logic fw, input logic [2:0] aluc, input logic [2:0] cond,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [3:0] rd);
    RegWriteD = rw; MemtoRegD = mtr; MemWriteD = mw; ALUSrcD = 1'b0;
    BranchD = br; FlagWriteD = fw; ALUControlD = aluc; CondD = cond;
    RD1D = rd1; RD2D = rd2; ExtImmD = 32'h0000_0010; RdD = rd;
  endtask

  task automatic randomize_inputs();
    logic [31:0] r;
    r = $urandom();
    RegWriteD = r[0]; MemtoRegD = r[1]; MemWriteD = r[2]; ALUSrcD = r[3];
    BranchD = r[4]; FlagWriteD = r[5]; ALUControlD = r[8:6]; CondD = r[11:9];
    StallE = (r[13:12] == 2'b00);
    FlushE = (r[16:14] == 3'b000);
    ALUFlagsE = r[20:17];
    RdD = r[24:21];
    RD1D = $urandom(); RD2D = $urandom(); ExtImmD = $urandom();
  endtask

  initial begin
    rst = 1'b0;
    StallE = 1'b0; FlushE = 1'b0; ALUFlagsE = 4'b0000;
    set_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst = 1'b1;

    // Warm up with random traffic so the reset pulse below clears real state.
    for (int i = 0; i < 12; i++) begin
      randomize_inputs();
      step("warm");
    end

    // 1. Asynchronous reset between edges, with every input (incl. stall and flush) nonzero.
    set_d(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 3'd1, 32'hFFFF_FFFF, 32'h1234_5678, 4'd8);
    ALUSrcD = 1'b1; ExtImmD = 32'hDEAD_BEEF; StallE = 1'b1; FlushE = 1'b1;
    ALUFlagsE = 4'b1111;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    chk("rst.ValidE0", 32'(ValidE), 32'd0);
    chk("rst.FlagsE0", 32'(FlagsE), 32'd0);
    #1 rst = 1'b1;
    StallE = 1'b0; FlushE = 1'b0;
    step("rst_release");
    chk("rst.RdE8", 32'(RdE), 32'd8);
    chk("rst.ValidE1", 32'(ValidE), 32'd1);

    // 2. add captured, then stalled for two cycles while D changes.
    ALUFlagsE = 4'b0000;
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'd5, 32'd3, 4'd2);
    step("add");
    chk("add.RD1E", RD1E, 32'd5);
    chk("add.RegWriteE", 32'(RegWriteE), 32'd1);
    for (int i = 0; i < 2; i++) begin
      set_d(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 3'd2, 32'd99 + 32'(i), 32'd7, 4'd11);
      StallE = 1'b1;
      step("add_stall");
      chk("stall.RD1E", RD1E, 32'd5);
      chk("stall.RegWriteE", 32'(RegWriteE), 32'd1);
    end
    StallE = 1'b0;

    // 3. sub -> beq, taken with Z=1 and not taken with Z=0.
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 32'd4, 32'd4, 4'd1);
    step("sub_z");
    ALUFlagsE = 4'b0100;
    set_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 32'd0, 32'd0, 4'd0);
    step("beq_z");
    chk("beq.FlagsE", 32'(FlagsE), 32'h4);
    chk("beq.taken", 32'(BranchTakenE), 32'd1);
    ALUFlagsE = 4'b0000;
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 32'd4, 32'd3, 4'd1);
    step("sub_nz");
    ALUFlagsE = 4'b0000;
    set_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 32'd0, 32'd0, 4'd0);
    step("beq_nz");
    chk("beq_nz.taken", 32'(BranchTakenE), 32'd0);

    // 4. GT/LT with N=1,V=0 then with flags clear.
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 32'd1, 32'd2, 4'd1);
    step("sub_neg");
    ALUFlagsE = 4'b1000;
    set_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 32'd0, 32'd0, 4'd0);
    step("bgt_neg");
    chk("bgt_neg.taken", 32'(BranchTakenE), 32'd0);
    ALUFlagsE = 4'b0000;
    set_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 32'd0, 32'd0, 4'd0);
    step("blt_neg");
    chk("blt_neg.taken", 32'(BranchTakenE), 32'd1);
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 32'd2, 32'd1, 4'd1);
    step("sub_pos");
    ALUFlagsE = 4'b0000;
    set_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 32'd0, 32'd0, 4'd0);
    step("bgt_pos");
    chk("bgt_pos.taken", 32'(BranchTakenE), 32'd1);
    set_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 32'd0, 32'd0, 4'd0);
    step("blt_pos");
    chk("blt_pos.taken", 32'(BranchTakenE), 32'd0);

    // 5. str with flush and stall at the same edge: flush wins, flags untouched.
    set_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'd1, 32'd1, 4'd7);
    step("pre_flush");
    begin
      logic [3:0] flags_before;
      flags_before = m_flags;
      ALUFlagsE = 4'b1011;
      set_d(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 32'd6, 32'd9, 4'd9);
      StallE = 1'b1; FlushE = 1'b1;
      step("flush");
      chk("flush.MemWriteE", 32'(MemWriteE), 32'd0);
      chk("flush.ValidE", 32'(ValidE), 32'd0);
      chk("flush.RdE", 32'(RdE), 32'd0);
      chk("flush.FlagsE", 32'(FlagsE), 32'(flags_before));
    end
    StallE = 1'b0; FlushE = 1'b0; ALUFlagsE = 4'b0000;

    // 6. Reserved condition never executes.
    set_d(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'b110, 32'd3, 32'd4, 4'd5);
    step("reserved");
    chk("rsv.RegWriteE", 32'(RegWriteE), 32'd0);
    chk("rsv.BranchTakenE", 32'(BranchTakenE), 32'd0);
    chk("rsv.ValidE", 32'(ValidE), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decode_execute_register.md
# decode_execute_register

Pipeline register between the decode stage (control unit and register file) and the execute stage (ALU, memory write path). Captures decode-stage control and data each cycle and supports stall (hold) and flush (bubble insertion). Owns the NZCV condition-flags register and evaluates branch conditions for the instruction currently in execute. Gated control outputs (`RegWriteE`, `MemWriteE`, `BranchTakenE`) are therefore final.

## Interface
- `WIDTH`, 32, datapath width of operands and extended immediate.
- `REG_BITS`, 4, register-index width.

- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous, active-low.
- `StallE` input 1: hold all E registers; flags register also holds.
- `FlushE` input 1: replace the captured instruction with a bubble.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `ALUSrcD` input 1 each: decode control.
- `BranchD` input 1: the instruction is a branch.
- `FlagWriteD` input 1: the instruction updates NZCV (sub, subi).
- `ALUControlD` input 3: ALU operation.
- `CondD` input 3: branch condition.
  - 000 always, 001 EQ, 010 NE, 011 GT, 100 LT.
  - 101–111 are reserved and evaluate as never.
- `RD1D`, `RD2D`, `ExtImmD` input WIDTH: operands and extended immediate.
- `RdD` input REG_BITS: destination index.
- `ALUFlagsE` input 4: NZCV produced by the ALU this cycle for the E instruction.
- `MemtoRegE`, `ALUSrcE` output 1 each: registered copies.
- `ALUControlE` output 3: registered copy.
- `RD1E`, `RD2E`, `ExtImmE` output WIDTH: registered copies.
- `RdE` output REG_BITS: registered copy.
- `RegWriteE`, `MemWriteE` output 1 each: registered value AND `ValidE` AND `CondExE`.
- `BranchTakenE` output 1: `ValidE` AND `BranchE` AND `CondExE`.
- `ValidE` output 1: the E slot holds a real instruction.
- `FlagsE` output 4: current NZCV register, ordered N,Z,C,V from MSB.

## Operation
- **Normal capture** (rising `clk`, `StallE`=0, `FlushE`=0):
  - All D inputs are registered.
  - `ValidE` is set to 1.
- **Stall** (`StallE`=1, `FlushE`=0): every E register and the flags register hold their values.
- **Flush** (`FlushE`=1, regardless of `StallE`; flush wins):
  - `ValidE` and all control registers are cleared to 0: RegWrite, MemtoReg, MemWrite, ALUSrc, Branch, FlagWrite, ALUControl, Cond.
  - The data registers (`RD1`, `RD2`, `ExtImm`, `Rd`) are also cleared to 0.
- **Flags register update:** on a rising edge, NZCV is loaded with `ALUFlagsE` when `ValidE` & `FlagWriteE` & !`StallE`. It is otherwise held.
  - The load uses the pre-edge contents of the E slot.
  - Flush does not block this update; only stall does.
- **Condition evaluation** (combinational from the registered Cond and the flags register, i.e. flags written by earlier instructions; `ALUFlagsE` is never used):
  - always: 1
  - EQ: Z
  - NE: !Z
  - GT: !Z & (N==V)
  - LT: N!=V
  - reserved codes: 0
- **Non-branch instructions** must arrive with `CondD`=000 so that their writes are not suppressed.
- **Reset** (`rst`=0, asynchronous): all registers, including flags, go to 0.
  - `ValidE`=0 and `FlagsE`=0000.
  - All outputs read 0.
  - Reset asserted mid-stall or mid-flush overrides both immediately.

## Timing
- Latency is 1 cycle from D inputs to E outputs.
- E outputs are combinational only from registers; there are no paths from D inputs to E outputs.
- A flag-writing instruction in E at cycle t updates `FlagsE` at the t+1 edge. A branch entering E at t+1 sees the new flags, so back-to-back sub→beq needs no stall.
- `StallE` and `FlushE` are sampled at the rising edge.
- A stall of N cycles keeps the same instruction visible on E outputs for N+1 cycles.
- A flush at the edge makes E outputs all-zero in the following cycle.
- Releasing `rst` takes effect at the first rising edge after deassertion. The first capture occurs at that edge if `StallE`=0.

## Test plan
1. **Reset:** drive all inputs nonzero and pulse `rst`=0 between clock edges.
   - All outputs are 0 immediately, without waiting for an edge.
   - After release, the first edge captures `RdD`=8 → `RdE`=8, `ValidE`=1.
2. **Capture add, then stall:** add (`RegWriteD`=1, `ALUControlD`=000, `RD1D`=5, `RD2D`=3, `CondD`=000), then `StallE`=1 for 2 cycles with different D inputs.
   - `RD1E`=5 and `RegWriteE`=1 are held for 3 cycles.
3. **sub then beq:** sub with `FlagWriteD`=1 and `ALUFlagsE`=0100 while the sub is in E, followed by beq (`BranchD`=1, `CondD`=001).
   - `FlagsE`=0100 and `BranchTakenE`=1 in the beq cycle.
   - The same sequence with `ALUFlagsE`=0000 gives `BranchTakenE`=0.
4. **GT/LT:** flags N=1,V=0.
   - bgt → `BranchTakenE`=0; blt → `BranchTakenE`=1.
   - Flags 0000: bgt → 1, blt → 0.
5. **Flush:** str (`MemWriteD`=1) with `FlushE`=1 and `StallE`=1 at the same edge.
   - Next cycle: `MemWriteE`=0, `ValidE`=0, `RdE`=0, and flags unchanged.
6. **Reserved condition:** `CondD`=110 with `RegWriteD`=1.
   - `RegWriteE`=0 and `BranchTakenE`=0.
